// File: rtl/ahfp_cordic_sched.sv
// Round-robin scheduler sharing one pipelined CORDIC between two requesters.
// Optional angle folding/result negation enabled by AHFP_CORDIC_SCHED_RANGE_EN.
module ahfp_cordic_sched #(
  parameter int LAT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic [31:0] req0_theta,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  input  logic [31:0] req1_theta,
  output logic [31:0] cordic_x_start,
  output logic [31:0] cordic_y_start,
  output logic [31:0] cordic_theta,
  input  logic [31:0] cordic_x_cos,
  output logic        res0_valid,
  output logic        res1_valid,
  output logic [31:0] res_data,
  output logic [4:0]  outstanding
);

  typedef struct packed {
    logic vld;
    logic id;
    logic neg;
  } tag_t;

  tag_t        tag_pipe [LAT:0];
  logic        ptr;
  logic        acc;
  logic        sel;
  logic [31:0] op_x, op_y, op_theta, th_fold, res_val;
  logic        neg;

  always_comb begin
    req0_ready = !rst && req0_valid && (!req1_valid || !ptr);
    req1_ready = !rst && req1_valid && (!req0_valid || ptr);
    acc        = req0_ready || req1_ready;
    sel        = req1_ready;
    op_x       = sel ? req1_x     : req0_x;
    op_y       = sel ? req1_y     : req0_y;
    op_theta   = sel ? req1_theta : req0_theta;
  end

`ifdef AHFP_CORDIC_SCHED_RANGE_EN
  localparam logic signed [31:0] HALF_PI = 32'sh3243F6A8;
  localparam logic        [31:0] PI      = 32'h6487ED51;
  logic signed [31:0] th_s;

  always_comb begin
    th_s    = op_theta;
    th_fold = op_theta;
    neg     = 1'b0;
    if (th_s > HALF_PI) begin
      th_fold = op_theta - PI;
      neg     = 1'b1;
    end else if (th_s < -HALF_PI) begin
      th_fold = op_theta + PI;
      neg     = 1'b1;
    end
  end

  assign res_val = tag_pipe[LAT].neg ? -cordic_x_cos : cordic_x_cos;
`else
  logic unused_neg;

  assign th_fold    = op_theta;
  assign neg        = 1'b0;
  assign res_val    = cordic_x_cos;
  assign unused_neg = tag_pipe[LAT].neg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr            <= 1'b0;
      cordic_x_start <= '0;
      cordic_y_start <= '0;
      cordic_theta   <= '0;
      res0_valid     <= 1'b0;
      res1_valid     <= 1'b0;
      res_data       <= '0;
      outstanding    <= '0;
      for (int k = 0; k <= LAT; k++) tag_pipe[k] <= '0;
    end else begin
      if (acc) begin
        ptr            <= ~sel;
        cordic_x_start <= op_x;
        cordic_y_start <= op_y;
        cordic_theta   <= th_fold;
      end
      tag_pipe[0] <= '{vld: acc, id: sel, neg: acc && neg};
      for (int k = 1; k <= LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
      // Last tag stage lines up with cordic_x_cos holding that op's result.
      res0_valid <= tag_pipe[LAT].vld && !tag_pipe[LAT].id;
      res1_valid <= tag_pipe[LAT].vld &&  tag_pipe[LAT].id;
      if (tag_pipe[LAT].vld) res_data <= res_val;
      case ({acc, tag_pipe[LAT].vld})
        2'b10:   outstanding <= outstanding + 5'd1;
        2'b01:   outstanding <= outstanding - 5'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: doc/ahfp_cordic_sched.md
AHFP_CORDIC_SCHED -- requirements
Module: ahfp_cordic_sched

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-high reset, rst.
REQ-002 Parameter LAT, default 10, SHALL be the number of clk edges from the CORDIC sampling its inputs to cordic_x_cos holding the result (LAT >= 2).
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port rst, input, 1 bit: synchronous reset, active high.
REQ-005 Ports req0_valid / req1_valid, input, 1 bit each: requester has an operation pending.
REQ-006 Ports req0_ready / req1_ready, output, 1 bit each: grant; an operation is accepted on an edge where valid and ready are both high.
REQ-007 Ports req0_x, req0_y, req0_theta, req1_x, req1_y, req1_theta, input, 32 bits each: operands; theta is signed Q3.29 radians.
REQ-008 Ports cordic_x_start, cordic_y_start, cordic_theta, output, 32 bits each: registered operands to the shared pipelined CORDIC.
REQ-009 Port cordic_x_cos, input, 32 bits: CORDIC result.
REQ-010 Ports res0_valid / res1_valid, output, 1 bit each: one-cycle result strobe per requester.
REQ-011 Port res_data, output, 32 bits: result shared by both requesters.
REQ-012 Port outstanding, output, 5 bits: number of operations currently in flight.

Function
REQ-013 Arbitration SHALL be round-robin with a 1-bit priority pointer: if only one requester is valid, it receives ready; if both are valid, the one named by the pointer receives ready.
REQ-014 The pointer SHALL switch to the other requester after every accepted operation, and SHALL be unchanged when no operation is accepted.
REQ-015 At most one ready SHALL be high in any cycle, ready SHALL never be high without the matching valid, and ready SHALL be combinational from the valids and the pointer.
REQ-016 No backpressure SHALL apply: one operation per cycle SHALL be accepted indefinitely.
REQ-017 On acceptance at edge t, the chosen operands SHALL be loaded into the cordic_* registers at edge t; when nothing is accepted, the cordic_* registers SHALL hold.
REQ-018 A tag shift register of depth LAT+1 SHALL carry {valid, requester id, negate flag} in lockstep with the CORDIC pipeline.
REQ-019 The result of an operation accepted at edge t SHALL be registered into res_data at edge t+LAT+1, with the matching resN_valid high for exactly the following cycle.
REQ-020 Bubble cycles SHALL produce no strobe, and res_data SHALL hold its last value when no strobe is issued.
REQ-021 outstanding SHALL increment on accept, decrement on result strobe, and stay unchanged when both occur on the same edge; its maximum is LAT+1.
REQ-022 Requester x and y SHALL be passed to the CORDIC unmodified.

Reset
REQ-023 While rst is high at an edge, all of the following SHALL be cleared: the pointer (to 0, so requester 0 has priority), all tag valid bits, outstanding, res0_valid, res1_valid, res_data and the cordic_* registers (to 0).
REQ-024 req0_ready and req1_ready SHALL be 0 in every cycle in which rst is high.
REQ-025 In-flight operations at reset SHALL be discarded, with no strobe emitted for them, including operations whose results arrive after reset deasserts.

Configuration
REQ-026 With macro AHFP_CORDIC_SCHED_RANGE_EN defined, angle folding SHALL be applied at accept:
  - theta > 0x3243F6A8 (pi/2): cordic_theta = theta - 0x6487ED51 and the negate flag is set;
  - theta < -0x3243F6A8: cordic_theta = theta + 0x6487ED51 and the negate flag is set;
  - otherwise theta passes through with the negate flag clear.
REQ-027 With the macro defined, a set negate flag SHALL produce res_data = two's-complement negation of cordic_x_cos.
REQ-028 Without the macro, theta SHALL pass through unmodified, the negate flag SHALL be constant 0, and the folding and negation logic SHALL NOT be present.

Verification
REQ-029 Reset, then drive req0_valid only for one cycle: req0_ready=1; res0_valid pulses exactly LAT+1 cycles after acceptance; outstanding goes 1 then 0.
REQ-030 Hold both valids for 4 cycles after reset: accepts occur in the order 0,1,0,1; res strobes arrive in the same order on consecutive cycles.
REQ-031 Drive continuous req1_valid for 20 cycles: 20 accepts back-to-back; outstanding saturates at LAT+1 = 11; 20 consecutive res1_valid strobes.
REQ-032 Assert rst with 5 operations in flight: no strobes follow; outstanding = 0; the next accepted operation returns normally.
REQ-033 With AHFP_CORDIC_SCHED_RANGE_EN defined, send theta = 0x5A000000: cordic_theta = 0xF578 12AF and the result is negated; with theta = 0x10000000 the value passes unchanged.
REQ-034 Without AHFP_CORDIC_SCHED_RANGE_EN, send theta = 0x5A000000: cordic_theta = 0x5A000000 and res_data equals cordic_x_cos.
